// File: rtl/sprite_queue_pkg.sv
// Shared sprite command types for the sprite draw queue.
// One record is six bytes on the MCU link.
package sprite_pkg;

    localparam int SPRITE_CMD_BYTES = 6;

    localparam logic [2:0] IDX_LAST = 3'(SPRITE_CMD_BYTES - 1);

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } sprite_cmd_t;

endpackage

// File: rtl/sprite_queue_if.sv
// Byte link from the MCU and draw-queue read side.
// master: MCU and sprite driver; slave: the queue.
interface sprite_queue_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_first;
    logic        in_ready;

    logic        sprite_queue_dequeue;
    logic        sprite_queue_is_empty;
    logic [7:0]  sprite_queue_sprite_id;
    logic [15:0] sprite_queue_sprite_x;
    logic [15:0] sprite_queue_sprite_y;
    logic [7:0]  sprite_queue_sprite_scale;

    modport master (
        output in_valid,
        output in_data,
        output in_first,
        output sprite_queue_dequeue,
        input  in_ready,
        input  sprite_queue_is_empty,
        input  sprite_queue_sprite_id,
        input  sprite_queue_sprite_x,
        input  sprite_queue_sprite_y,
        input  sprite_queue_sprite_scale
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_first,
        input  sprite_queue_dequeue,
        output in_ready,
        output sprite_queue_is_empty,
        output sprite_queue_sprite_id,
        output sprite_queue_sprite_x,
        output sprite_queue_sprite_y,
        output sprite_queue_sprite_scale
    );

endinterface

// File: rtl/sprite_queue_assembler.sv
// Assembles link bytes into sprite records.
// A byte flagged first always restarts the record.
module sprite_cmd_assembler
    import sprite_pkg::*;
(
    input  logic        clock,
    input  logic        fb_resetting,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    input  logic        i_first,
    output logic        o_at_last,
    output logic        o_push,
    output sprite_cmd_t o_record,
    output logic        o_resync_err
);

    logic [2:0]  r_idx;
    logic [39:0] r_hold;
    logic        r_resync_err;
    logic [2:0]  w_idx;

    assign w_idx        = i_first ? 3'd0 : r_idx;
    assign o_at_last    = (r_idx == IDX_LAST);
    assign o_push       = i_accept && (w_idx == IDX_LAST);
    assign o_record     = {r_hold, i_data};
    assign o_resync_err = r_resync_err;

    // Byte index advance and sticky resync flag
    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            r_idx        <= 3'd0;
            r_resync_err <= 1'b0;
        end else if (i_accept) begin
            r_idx <= (w_idx == IDX_LAST) ? 3'd0 : w_idx + 3'd1;
            if (i_first && (r_idx != 3'd0))
                r_resync_err <= 1'b1;
        end
    end

    // Capture bytes 0..4; byte 5 goes straight into the push
    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            r_hold <= 40'd0;
        end else if (i_accept) begin
            case (w_idx)
                3'd0:    r_hold[39:32] <= i_data;
                3'd1:    r_hold[31:24] <= i_data;
                3'd2:    r_hold[23:16] <= i_data;
                3'd3:    r_hold[15:8]  <= i_data;
                3'd4:    r_hold[7:0]   <= i_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sprite_queue.sv
// Sprite command queue: byte assembler feeding a FWFT FIFO.
// Only the record-completing byte stalls when the FIFO is full.
module sprite_queue
    import sprite_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   fb_resetting,
    sprite_queue_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   resync_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    sprite_cmd_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_at_last;
    logic          w_push;
    logic          w_pop;
    sprite_cmd_t   w_record;
    sprite_cmd_t   w_head;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_pop    = bus.sprite_queue_dequeue && !w_empty;
    assign w_accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready = !(w_full && w_at_last);

    sprite_cmd_assembler u_asm (
        .clock        (clock),
        .fb_resetting (fb_resetting),
        .i_accept     (w_accept),
        .i_data       (bus.in_data),
        .i_first      (bus.in_first),
        .o_at_last    (w_at_last),
        .o_push       (w_push),
        .o_record     (w_record),
        .o_resync_err (resync_err)
    );

    // Head is forced to zero while empty so reset reads clean
    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign bus.sprite_queue_is_empty     = w_empty;
    assign bus.sprite_queue_sprite_id    = w_head.id;
    assign bus.sprite_queue_sprite_x     = w_head.x;
    assign bus.sprite_queue_sprite_y     = w_head.y;
    assign bus.sprite_queue_sprite_scale = w_head.scale;
    assign count                         = r_count;

    // Record storage, written on push only
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_record;
    end

    // Pointers and occupancy
    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sprite_queue.md
# sprite_queue

Sprite command queue that feeds the sprite renderers: it receives a byte stream of sprite draw records from the game MCU link, assembles them into complete records, and buffers them in a first-word-fall-through FIFO. The read side is exactly the draw-queue interface the sprite driver consumes (`dequeue`, `is_empty`, id/x/y/scale at head). The queue is flushed whenever the framebuffer is reset, so each frame's sprite list starts empty.

## Interface
- `DEPTH`, 64: record capacity; power of two, ≥2.
- `clock` in 1: system clock.
- `fb_resetting` in 1: reset; asynchronous, active-high.
- `in_valid` in 1: byte valid from MCU link.
- `in_data` in 8: record byte.
- `in_first` in 1: qualifies `in_data` as byte 0 (id) of a record.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `sprite_queue_dequeue` in 1: pop head record.
- `sprite_queue_is_empty` out 1: no record available.
- `sprite_queue_sprite_id` out 8: head record id.
- `sprite_queue_sprite_x` out 16: head x.
- `sprite_queue_sprite_y` out 16: head y.
- `sprite_queue_sprite_scale` out 8: head scale.
- `count` out clog2(DEPTH)+1: records stored.
- `resync_err` out 1: sticky; a partial record was discarded.

## Operation
- Record = 6 bytes, in order: id, x[15:8], x[7:0], y[15:8], y[7:0], scale (big-endian coordinates).
- Assembler byte index `idx` 0..5. Each accepted byte is stored into field `idx`. Then `idx` increments, wrapping 5→0.
- Accepted byte with `in_first=1` is always taken as byte 0. If `idx≠0` at that moment, the partial record is discarded and `resync_err` is set. `resync_err` is cleared only by reset.
- Accepting byte 5 pushes the complete record (5 held bytes + incoming scale) into the FIFO in that same cycle.
- `in_ready = !(full && idx==5)`. Bytes 0–4 are always accepted, even when the FIFO is full. Only the pushing byte stalls.
- FIFO: register array of DEPTH × 48 bits, with rd/wr pointers and `count`. Head outputs come from `mem[rd_ptr]`. Head outputs are don't-care while empty but must not glitch while non-empty.
- A pop occurs on `sprite_queue_dequeue && !sprite_queue_is_empty`. Dequeue while empty is ignored, with no pointer or count change.
- Push and pop in the same cycle (non-empty): `count` is unchanged and both pointers advance.
- Push while empty with dequeue asserted: the pop is ignored and the record is retained.
- Pointers wrap modulo DEPTH. `full = (count==DEPTH)`.
- Reset (async, any time, including mid-record or mid-dequeue):
  - pointers, `count` and `idx` go to 0;
  - `sprite_queue_is_empty`=1, `in_ready`=1, `resync_err`=0;
  - head data outputs read as 0;
  - all queued and partial records are lost.

## Timing
- Byte-to-visible latency: the record is pushed on the clock edge that accepts byte 5. From the next cycle, `is_empty`=0 and the head fields are valid.
- Pop latency: after a dequeue edge, the next record, or `is_empty`=1, is visible in the following cycle.
- `is_empty`, `count` and `in_ready` are registered or derived from registered state only. There is no combinational path from `sprite_queue_dequeue` to `in_ready`.
- Consumer handshake: the consumer pulses dequeue for one cycle and samples `is_empty` again only afterwards. Holding dequeue high pops one record per cycle.
- Throughput: 1 byte/clock in, 1 record/clock out.

## Structure
- Shared package `sprite_pkg`:
  - `sprite_cmd_t` packed struct {id[7:0], x[15:0], y[15:0], scale[7:0]};
  - constant `SPRITE_CMD_BYTES = 6`.
- Sub-module `sprite_cmd_assembler`: holds the byte index, the field registers, resync detection, and drives push/record.
- The top level contains the FIFO storage, pointers and count, plus the `in_ready` gating.

## Test plan
- Reset, then idle: `sprite_queue_is_empty`=1, `count`=0, `in_ready`=1, `resync_err`=0.
- Send 03,01,2C,00,64,80 (first flag on 03):
  - next cycle `is_empty`=0, id=3, x=300, y=100, scale=128, `count`=1.
- Dequeue pulse: next cycle `is_empty`=1, `count`=0. A further dequeue while empty leaves pointers and count at 0.
- DEPTH=4: enqueue 4 records (ids 1–4), then send 5 bytes of id 5:
  - `in_ready` drops before the sixth byte;
  - dequeue once, then id 2 appears at head, `in_ready` rises, the sixth byte is accepted, and `count` returns to 4;
  - drain in order 2,3,4,5.
- Resync: send 3 bytes, then 07 with `in_first`, plus 5 more bytes → `resync_err`=1, and a single record id=7 is queued.
- With 2 records queued and `idx`=2, assert `fb_resetting` asynchronously mid-cycle:
  - outputs immediately become `is_empty`=1, `count`=0;
  - after release, a fresh 6-byte record enqueues correctly.
